// File: rtl/bus_xfer_ctrl.sv
// Sequences MOVE/LOAD/FETCH transfers between R bus registers over a shared tristate bus.
// Done pulses in the 3rd cycle after Start is sampled; Start is ignored (never queued) until the block is back in IDLE.
module bus_xfer_ctrl #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [1:0]           Op,
    input  logic [$clog2(R)-1:0] Src,
    input  logic [$clog2(R)-1:0] Dst,
    input  logic [N-1:0]         Din,
    inout  wire  [N-1:0]         Bus,
    output logic [R-1:0]         RD_n,
    output logic [R-1:0]         WR_n,
    output logic [N-1:0]         Dout,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Err
);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;

    localparam logic [1:0] OP_MOVE = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_RSVD = 2'b11;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [$clog2(R)-1:0] src_q, src_d;
    logic [$clog2(R)-1:0] dst_q, dst_d;
    logic [N-1:0]         din_q, din_d;
    logic [R-1:0]         rd_n_q, rd_n_d;
    logic [R-1:0]         wr_n_q, wr_n_d;
    logic                 bus_oe_q, bus_oe_d;
    logic [N-1:0]         dout_q, dout_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src_d    = src_q;
        dst_d    = dst_q;
        din_d    = din_q;
        dout_d   = dout_q;
        rd_n_d   = '1;
        wr_n_d   = '1;
        bus_oe_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Op == OP_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = SETUP;
                        op_d    = Op;
                        src_d   = Src;
                        dst_d   = Dst;
                        din_d   = Din;
                    end
                end
            end
            SETUP: state_d = XFER;
            XFER: begin
                state_d = DONE;
                if (op_q != OP_LOAD) begin
                    dout_d = Bus;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes and bus enable are decoded from the next state so every output leaves a flop.
        case (state_d)
            SETUP, XFER: begin
                busy_d = 1'b1;
                if (op_d == OP_LOAD) begin
                    bus_oe_d = 1'b1;
                end else begin
                    rd_n_d[src_d] = 1'b0;
                end
                if (state_d == XFER &&
                    (op_d == OP_LOAD || (op_d == OP_MOVE && src_d != dst_d))) begin
                    wr_n_d[dst_d] = 1'b0;
                end
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q  <= IDLE;
            op_q     <= OP_MOVE;
            src_q    <= '0;
            dst_q    <= '0;
            din_q    <= '0;
            rd_n_q   <= '1;
            wr_n_q   <= '1;
            bus_oe_q <= 1'b0;
            dout_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            din_q    <= din_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            bus_oe_q <= bus_oe_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign Bus  = bus_oe_q ? din_q : {N{1'bz}};
    assign RD_n = rd_n_q;
    assign WR_n = wr_n_q;
    assign Dout = dout_q;
    assign Busy = busy_q;
    assign Done = done_q;
    assign Err  = err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: bus-register slave, transaction-level reference model, per-cycle compare, directed commands.
module tb_bus_xfer_ctrl;
    localparam int N = 8;
    localparam int R = 4;
    localparam logic [N-1:0] PROBE = 8'h3C;

    logic           Clk   = 1'b0;
    logic           Rst   = 1'b0;
    logic           Start = 1'b0;
    logic [1:0]     Op    = 2'b00;
    logic [1:0]     Src   = 2'd0;
    logic [1:0]     Dst   = 2'd0;
    logic [N-1:0]   Din   = '0;
    wire  [N-1:0]   Bus;
    logic [R-1:0]   RD_n;
    logic [R-1:0]   WR_n;
    logic [N-1:0]   Dout;
    logic           Busy;
    logic           Done;
    logic           Err;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;

    bus_xfer_ctrl #(.N(N), .R(R)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .Src(Src), .Dst(Dst),
        .Din(Din), .Bus(Bus), .RD_n(RD_n), .WR_n(WR_n), .Dout(Dout),
        .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a command is a 3-cycle transaction counted from the accepting edge.
    int           phase = 0;
    logic         armed = 1'b0;
    logic [1:0]   m_op  = 2'b00;
    logic [1:0]   m_src = 2'd0;
    logic [1:0]   m_dst = 2'd0;
    logic [N-1:0] m_din = '0;
    logic [N-1:0] m_dout = '0;
    logic         m_err = 1'b0;
    logic [N-1:0] m_regs [R];
    logic [N-1:0] s_regs [R];
    logic         exp_drive;

    assign exp_drive = armed && (phase == 1 || phase == 2) && m_op == 2'b01;

    // Slave registers plus a probe pattern that occupies the bus whenever nobody else should.
    logic         tb_oe;
    logic [N-1:0] tb_dat;
    always_comb begin
        tb_oe  = 1'b0;
        tb_dat = PROBE;
        for (int i = 0; i < R; i++) begin
            if (!RD_n[i] && !tb_oe) begin
                tb_oe  = 1'b1;
                tb_dat = s_regs[i];
            end
        end
        if (!tb_oe && armed && !exp_drive) begin
            tb_oe  = 1'b1;
            tb_dat = PROBE;
        end
    end
    assign Bus = tb_oe ? tb_dat : {N{1'bz}};

    always @(negedge Clk) begin
        for (int i = 0; i < R; i++) begin
            if (!WR_n[i]) s_regs[i] = Bus;
        end
    end

    always @(posedge Clk) begin
        if (!Rst) begin
            armed  = 1'b1;
            phase  = 0;
            m_dout = '0;
            m_err  = 1'b0;
            for (int i = 0; i < R; i++) m_regs[i] = s_regs[i];
        end else begin
            m_err = 1'b0;
            if (phase == 2) begin
                if (m_op != 2'b01) m_dout = m_regs[m_src];
                if (m_op == 2'b01) m_regs[m_dst] = m_din;
                else if (m_op == 2'b00) m_regs[m_dst] = m_regs[m_src];
            end
            if (phase == 0) begin
                if (Start) begin
                    if (Op == 2'b11) begin
                        m_err = 1'b1;
                    end else begin
                        m_op  = Op;
                        m_src = Src;
                        m_dst = Dst;
                        m_din = Din;
                        phase = 1;
                    end
                end
            end else if (phase == 3) begin
                phase = 0;
            end else begin
                phase = phase + 1;
            end
        end
    end

    logic [R-1:0] e_rd, e_wr;
    logic [N-1:0] e_bus;
    logic         e_act;
    always @(negedge Clk) begin
        if (armed) begin
            e_act = (phase == 1 || phase == 2);
            e_rd  = '1;
            e_wr  = '1;
            if (e_act && m_op != 2'b01) e_rd[m_src] = 1'b0;
            if (phase == 2 && (m_op == 2'b01 || (m_op == 2'b00 && m_src != m_dst)))
                e_wr[m_dst] = 1'b0;
            e_bus = !e_act ? PROBE : (m_op == 2'b01 ? m_din : m_regs[m_src]);
            chk("model_rd_n", RD_n, e_rd);
            chk("model_wr_n", WR_n, e_wr);
            chk("model_bus",  Bus,  e_bus);
            chk("model_dout", Dout, m_dout);
            chk("model_busy", Busy, e_act);
            chk("model_done", Done, phase == 3);
            chk("model_err",  Err,  m_err);
            chk("rd_n_onehot", $countones(~RD_n) <= 1, 1);
            chk("wr_n_onehot", $countones(~WR_n) <= 1, 1);
            if (Done) done_seen++;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Leaves the caller just after the accepting edge, i.e. in cycle 1 of the command.
    task automatic issue(input logic [1:0] op, input logic [1:0] s, input logic [1:0] d,
                         input logic [N-1:0] din);
        step();
        Op = op; Src = s; Dst = d; Din = din; Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    int d0;

    initial begin
        for (int i = 0; i < R; i++) s_regs[i] = N'((i + 1) * 16);

        // Reset held for two edges
        Rst = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_rd_n", RD_n, 4'hF);
        chk("rst_wr_n", WR_n, 4'hF);
        chk("rst_bus_z", Bus, PROBE);
        chk("rst_dout", Dout, 8'h00);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_err",  Err,  0);
        Rst = 1'b1;

        // LOAD A5 -> reg2
        d0 = done_seen;
        issue(2'b01, 2'd0, 2'd2, 8'hA5);
        @(negedge Clk);
        chk("load_setup_bus", Bus, 8'hA5);
        chk("load_setup_wr", WR_n, 4'hF);
        chk("load_setup_busy", Busy, 1);
        @(negedge Clk);
        chk("load_xfer_wr", WR_n, 4'b1011);
        chk("load_xfer_bus", Bus, 8'hA5);
        @(negedge Clk);
        chk("load_done", Done, 1);
        chk("load_dout_kept", Dout, 8'h00);
        chk("load_reg2", s_regs[2], 8'hA5);

        // MOVE reg2 -> reg1
        issue(2'b00, 2'd2, 2'd1, 8'h00);
        @(negedge Clk);
        chk("move_setup_rd", RD_n, 4'b1011);
        chk("move_setup_wr", WR_n, 4'hF);
        @(negedge Clk);
        chk("move_xfer_rd", RD_n, 4'b1011);
        chk("move_xfer_wr", WR_n, 4'b1101);
        @(negedge Clk);
        chk("move_done", Done, 1);
        chk("move_dout", Dout, 8'hA5);
        chk("move_reg1", s_regs[1], 8'hA5);

        // FETCH reg0, then reg1
        issue(2'b10, 2'd0, 2'd0, 8'h00);
        repeat (3) @(negedge Clk);
        chk("fetch0_dout", Dout, 8'h10);
        issue(2'b10, 2'd1, 2'd0, 8'h00);
        @(negedge Clk);
        chk("fetch1_setup_wr", WR_n, 4'hF);
        @(negedge Clk);
        chk("fetch1_xfer_wr", WR_n, 4'hF);
        @(negedge Clk);
        chk("fetch1_done", Done, 1);
        chk("fetch1_dout", Dout, 8'hA5);

        // Self-MOVE reg3 -> reg3
        issue(2'b00, 2'd3, 2'd3, 8'h00);
        @(negedge Clk);
        @(negedge Clk);
        chk("self_xfer_wr", WR_n, 4'hF);
        chk("self_xfer_rd", RD_n, 4'b0111);
        @(negedge Clk);
        chk("self_done", Done, 1);
        chk("self_dout", Dout, 8'h40);

        // Reserved op
        issue(2'b11, 2'd1, 2'd2, 8'h77);
        @(negedge Clk);
        chk("rsvd_err", Err, 1);
        chk("rsvd_busy", Busy, 0);
        chk("rsvd_rd", RD_n, 4'hF);
        chk("rsvd_wr", WR_n, 4'hF);
        @(negedge Clk);
        chk("rsvd_err_clear", Err, 0);

        // Overlap: Start held through SETUP, XFER and DONE
        d0 = done_seen;
        issue(2'b01, 2'd0, 2'd0, 8'h5A);
        @(negedge Clk);
        Op = 2'b01; Dst = 2'd3; Din = 8'hFF; Start = 1'b1;
        repeat (2) @(negedge Clk);
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (6) @(negedge Clk);
        chk("ovl_one_done", done_seen - d0, 1);
        chk("ovl_reg0", s_regs[0], 8'h5A);
        chk("ovl_reg3", s_regs[3], 8'h40);
        chk("ovl_idle", Busy, 0);

        // Reset during XFER of a LOAD
        d0 = done_seen;
        issue(2'b01, 2'd0, 2'd1, 8'hC3);
        @(negedge Clk);
        @(negedge Clk);
        chk("abort_xfer_wr", WR_n, 4'b1101);
        Rst = 1'b0;
        @(negedge Clk);
        chk("abort_rd", RD_n, 4'hF);
        chk("abort_wr", WR_n, 4'hF);
        chk("abort_bus_z", Bus, PROBE);
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        Rst = 1'b1;
        repeat (5) @(negedge Clk);
        chk("abort_no_done", done_seen - d0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the shared data bus width in bits.
REQ-002 The block SHALL have parameter R, default 4, meaning the number of attached bus registers (power of 2, at least 2).
REQ-003 The block SHALL have port Clk, input, 1, the rising edge of which updates all controller state.
REQ-004 The block SHALL have port Rst, input, 1, a synchronous, active-low reset.
REQ-005 The block SHALL have port Start, input, 1, a command request sampled only in IDLE.
REQ-006 The block SHALL have port Op, input, 2: 00 MOVE (reg Src -> reg Dst), 01 LOAD (Din -> reg Dst), 10 FETCH (reg Src -> Dout), 11 reserved.
REQ-007 The block SHALL have ports Src and Dst, input, clog2(R) each, giving the source and destination register indices.
REQ-008 The block SHALL have port Din, input, N, the LOAD data.
REQ-009 The block SHALL have port Bus, inout, N, the shared tristate data bus.
REQ-010 The block SHALL have port RD_n, output, R, one-hot-low per-register read enables.
REQ-011 The block SHALL have port WR_n, output, R, one-hot-low per-register write enables.
REQ-012 The block SHALL have port Dout, output, N, the data captured from Bus by MOVE/FETCH.
REQ-013 The block SHALL have port Busy, output, 1, high while a command is in progress.
REQ-014 The block SHALL have port Done, output, 1, a one-cycle completion pulse.
REQ-015 The block SHALL have port Err, output, 1, a one-cycle pulse on a reserved Op.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, XFER and DONE; all outputs SHALL be driven from registers, with no combinational glitches on RD_n or WR_n.
REQ-017 In IDLE with Start=1 and Op!=11, the block SHALL latch Op/Src/Dst/Din on that edge, go to SETUP and set Busy=1.
REQ-018 In IDLE with Start=1 and Op=11, the block SHALL pulse Err for 1 cycle, remain in IDLE and assert no strobes.
REQ-019 In SETUP, MOVE/FETCH SHALL drive RD_n[Src]=0; LOAD SHALL drive Bus=Din; all WR_n SHALL be 1.
REQ-020 In XFER, the SETUP drive SHALL be held, and WR_n[Dst]=0 SHALL be asserted for MOVE/LOAD, so the slave latches a Bus value stable for a full cycle on the falling edge.
REQ-021 A MOVE with Src==Dst SHALL assert no WR_n but otherwise keep identical timing.
REQ-022 On the edge leaving XFER, MOVE/FETCH SHALL capture Bus into Dout; LOAD SHALL leave Dout unchanged.
REQ-023 In DONE, all RD_n/WR_n SHALL be 1, Bus SHALL be Z, Busy=0 and Done=1 for exactly 1 cycle; the next state SHALL be IDLE.
REQ-024 Latency SHALL be: Done high in the 3rd cycle after the Start-sampling edge, with a new Start accepted no sooner than the cycle after Done.
REQ-025 Start while Busy or in DONE SHALL be ignored, with no queuing.
REQ-026 The controller SHALL never drive Bus while any RD_n bit is 0, and at most one RD_n bit and one WR_n bit SHALL be 0 at any time.
REQ-027 Outside LOAD SETUP/XFER, Bus SHALL be Z.

Reset
REQ-028 With Rst=0 at a rising edge, the block SHALL go to IDLE with RD_n and WR_n all 1, Bus Z, Dout=0 and Busy, Done and Err all 0.
REQ-029 Reset mid-command SHALL abort the command immediately, with no Done pulse; the slave register contents are then undefined-by-spec and need not be checked.
REQ-030 Start SHALL be ignored while Rst=0.

Verification
REQ-031 The bench SHALL cover reset: hold Rst=0 for 2 cycles -> RD_n=WR_n=4'hF, Bus=Z, Dout=0, Busy=Done=0.
REQ-032 The bench SHALL cover LOAD: Op=01, Dst=2, Din=8'hA5 -> SETUP Bus=A5; XFER WR_n=4'b1011; Done in cycle 3; slave reg2 holds A5.
REQ-033 The bench SHALL cover MOVE: after REQ-032, Op=00, Src=2, Dst=1 -> RD_n=4'b1011 in SETUP/XFER, WR_n=4'b1101 in XFER, Dout=A5, reg1=A5.
REQ-034 The bench SHALL cover FETCH and self-MOVE: Op=10, Src=1 -> Dout=A5 with WR_n=F throughout; Op=00, Src=Dst=3 -> WR_n=F, Done in cycle 3.
REQ-035 The bench SHALL cover illegal/overlap: Op=11 -> Err pulse, no strobes; Start reasserted in SETUP -> ignored, exactly one Done.
REQ-036 The bench SHALL cover reset mid-op: Rst=0 during XFER of a LOAD -> next cycle all strobes 1, Bus Z, no Done; the bench SHALL assert REQ-026 on every cycle of every test.
